// File: rtl/uart_char_rx.sv
// uart_char_rx: oversampled 8N1-style UART receiver with 3-sample majority vote,
// start-glitch rejection and framing-error detection.
//   i_clk       system clock
//   i_rst       asynchronous active-high reset
//   i_rx        raw serial line, idle high, asynchronous to i_clk
//   i_baud      one-cycle pulse at OVERSAMPLE x baud rate
//   o_char      last correctly framed character, held until the next one
//   o_finished  one-cycle strobe, o_char was updated
//   o_frame_err one-cycle strobe, stop bit sampled low
//   o_busy      high whenever the receiver is not idle
module uart_char_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx,
    input  logic                 i_baud,
    output logic [DATA_BITS-1:0] o_char,
    output logic                 o_finished,
    output logic                 o_frame_err,
    output logic                 o_busy
);
    localparam int M  = OVERSAMPLE / 2;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [SW-1:0] S_VOTE = SW'(M + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t                 state_q, state_d;
    logic                   meta_q, rx_s_q;
    logic [1:0]             hist_q;
    logic [SW-1:0]          s_q, s_d;
    logic [BW-1:0]          b_q, b_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   char_q, char_d;
    logic                   fin_q, fin_d;
    logic                   err_q, err_d;
    logic                   vote;

    // hist_q holds the samples from the two previous ticks, so at s=M+1 it
    // carries the s=M-1 and s=M samples alongside the live one.
    assign vote = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            hist_q  <= 2'b11;
            state_q <= IDLE;
            s_q     <= '0;
            b_q     <= '0;
            shift_q <= '0;
            char_q  <= '0;
            fin_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            meta_q  <= i_rx;
            rx_s_q  <= meta_q;
            if (i_baud) hist_q <= {hist_q[0], rx_s_q};
            state_q <= state_d;
            s_q     <= s_d;
            b_q     <= b_d;
            shift_q <= shift_d;
            char_q  <= char_d;
            fin_q   <= fin_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        b_d     = b_q;
        shift_d = shift_q;
        char_d  = char_q;
        fin_d   = 1'b0;
        err_d   = 1'b0;
        if (i_baud) begin
            s_d = s_q + 1'b1;
            case (state_q)
                IDLE: begin
                    // the detecting tick is s=0 of the start bit
                    state_d = rx_s_q ? IDLE : START;
                    s_d     = rx_s_q ? '0 : SW'(1);
                end
                START: begin
                    if (s_q == S_VOTE && vote) begin
                        state_d = IDLE;
                        s_d     = '0;
                    end else if (s_q == S_LAST) begin
                        state_d = DATA;
                        s_d     = '0;
                        b_d     = '0;
                    end
                end
                DATA: begin
                    if (s_q == S_VOTE) shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        b_d     = b_q + 1'b1;
                        state_d = (b_q == B_LAST) ? STOP : DATA;
                    end
                end
                STOP: begin
                    // decide mid stop bit so the next start edge is caught early
                    if (s_q == S_VOTE) begin
                        state_d = vote ? IDLE : BRK;
                        char_d  = vote ? shift_q : char_q;
                        fin_d   = vote;
                        err_d   = !vote;
                        s_d     = '0;
                    end
                end
                BRK: begin
                    s_d     = '0;
                    state_d = rx_s_q ? IDLE : BRK;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign o_char      = char_q;
    assign o_finished  = fin_q;
    assign o_frame_err = err_q;
    assign o_busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_char_rx.sv
// tb_uart_char_rx: scoreboard bench for uart_char_rx with directed and random frames.
`timescale 1ns/1ps
module tb_uart_char_rx;
    localparam int TICK = 3;
    localparam int BIT  = 16 * TICK;

    typedef struct packed {
        logic       err;
        logic [7:0] ch;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       baud;
    logic [7:0] o_char;
    logic       o_finished;
    logic       o_frame_err;
    logic       o_busy;

    int         checks = 0;
    int         errors = 0;
    ev_t        exp_q[$];
    longint     fin_times[$];
    logic [7:0] last_good = 8'h00;
    int         lat;

    uart_char_rx dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_rx(rx),
        .i_baud(baud),
        .o_char(o_char),
        .o_finished(o_finished),
        .o_frame_err(o_frame_err),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    initial begin
        baud = 1'b0;
        forever begin
            repeat (TICK - 1) @(negedge clk);
            baud = 1'b1;
            @(negedge clk);
            baud = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic hold(input logic v, input int clocks);
        rx = v;
        repeat (clocks) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] ch, input logic stop);
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(ch[i], BIT);
        hold(stop, BIT);
    endtask

    task automatic expect_fin(input logic [7:0] ch);
        exp_q.push_back('{err: 1'b0, ch: ch});
        last_good = ch;
    endtask

    task automatic expect_err();
        exp_q.push_back('{err: 1'b1, ch: last_good});
    endtask

    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (o_finished || o_frame_err) begin
                chk("strobes_exclusive", {31'b0, o_finished & o_frame_err}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got fin=%0b err=%0b char=%02h expected none",
                             o_finished, o_frame_err, o_char);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_kind_err", {31'b0, o_frame_err}, {31'b0, e.err});
                    chk("strobe_char", {24'b0, o_char}, {24'b0, e.ch});
                    chk("busy_on_strobe", {31'b0, o_busy}, {31'b0, e.err});
                end
                if (o_finished) fin_times.push_back($time);
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ch;
        int         n;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset_char", {24'b0, o_char}, 32'h0);
        chk("reset_finished", {31'b0, o_finished}, 32'h0);
        chk("reset_frame_err", {31'b0, o_frame_err}, 32'h0);
        chk("reset_busy", {31'b0, o_busy}, 32'h0);
        rst = 1'b0;
        hold(1'b1, 10);

        // single '$' with latency measurement
        expect_fin(8'h24);
        lat = 0;
        fork
            send_frame(8'h24, 1'b1);
            begin
                while (!o_finished && lat < 600) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        chk_range("latency_clocks", lat, 461, 466);
        hold(1'b1, BIT);

        // start glitch of 4 ticks
        hold(1'b0, 4 * TICK);
        chk("glitch_busy_high", {31'b0, o_busy}, 32'h1);
        hold(1'b1, 20 * TICK);
        chk("glitch_busy_low", {31'b0, o_busy}, 32'h0);
        chk("glitch_char_kept", {24'b0, o_char}, 32'h24);

        // framing error, break, recovery
        expect_fin(8'h41);
        send_frame(8'h41, 1'b1);
        hold(1'b1, 20);
        expect_err();
        send_frame(8'h47, 1'b0);
        hold(1'b0, 40 * TICK);
        chk("brk_busy", {31'b0, o_busy}, 32'h1);
        chk("brk_char_held", {24'b0, o_char}, 32'h41);
        hold(1'b1, 30);
        expect_fin(8'h2A);
        send_frame(8'h2A, 1'b1);
        hold(1'b1, BIT);

        // back-to-back "$GP"
        expect_fin(8'h24);
        expect_fin(8'h47);
        expect_fin(8'h50);
        send_frame(8'h24, 1'b1);
        send_frame(8'h47, 1'b1);
        send_frame(8'h50, 1'b1);
        hold(1'b1, BIT);
        n = fin_times.size();
        if (n >= 3) begin
            chk_range("b2b_spacing_1", fin_times[n-2] - fin_times[n-3], 4770, 4830);
            chk_range("b2b_spacing_2", fin_times[n-1] - fin_times[n-2], 4770, 4830);
        end else begin
            checks++;
            errors++;
            $display("FAIL b2b_count: got %0d strobes expected at least 3", n);
        end

        // one-tick low spike in the middle of data bit 2 of 0xFF
        expect_fin(8'hFF);
        hold(1'b0, BIT);
        hold(1'b1, 2 * BIT);
        hold(1'b1, 8 * TICK);
        hold(1'b0, TICK);
        hold(1'b1, BIT - 9 * TICK);
        hold(1'b1, 6 * BIT);
        hold(1'b1, BIT);
        hold(1'b1, BIT);

        // reset during data bit 3 of 0x55
        hold(1'b0, BIT);
        hold(1'b1, BIT);
        hold(1'b0, BIT);
        hold(1'b1, BIT);
        hold(1'b0, 20);
        rst = 1'b1;
        rx  = 1'b1;
        #1;
        chk("midreset_char", {24'b0, o_char}, 32'h0);
        chk("midreset_busy", {31'b0, o_busy}, 32'h0);
        chk("midreset_finished", {31'b0, o_finished}, 32'h0);
        last_good = 8'h00;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        hold(1'b1, BIT);
        expect_fin(8'h0D);
        send_frame(8'h0D, 1'b1);
        hold(1'b1, BIT);

        // random traffic with occasional framing errors
        for (int k = 0; k < 30; k++) begin
            ch = 8'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                expect_err();
                send_frame(ch, 1'b0);
                hold(1'b0, $urandom_range(0, 150));
                hold(1'b1, $urandom_range(6, 60));
            end else begin
                expect_fin(ch);
                send_frame(ch, 1'b1);
                hold(1'b1, $urandom_range(0, 60));
            end
        end

        hold(1'b1, 200);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
